// File: rtl/placar_escalonador.sv
// placar_escalonador: scans enemy-life slices for deaths, merges ball-hit bonus into one adder,
// and gates scoring with the game-state FSM.
module placar_escalonador #(
  parameter int N_INIMIGOS  = 1000,
  parameter int FATIA       = 50,
  parameter int PLACAR_MAX  = 999,
  parameter int PONTOS_BOLA = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [N_INIMIGOS-1:0] inimigosvida,
  input  logic                  bolaRebatida,
  input  logic                  iniciarJogo,
  input  logic                  perdeuJogo,
  input  logic                  reiniciarJogo,
  output logic [9:0]            placarAtual,
  output logic [9:0]            placarMaximo,
  output logic [1:0]            estado,
  output logic                  pronto,
  output logic                  pontuou
);
  localparam int NF = N_INIMIGOS / FATIA;
  localparam int KW = NF > 1 ? $clog2(NF) : 1;
  localparam int MW = $clog2(FATIA + 1);
  localparam int SW = 11;
  typedef enum logic [1:0] {OCIOSO = 2'b00, JOGANDO = 2'b01, FIM = 2'b10} estado_t;
  estado_t st, st_n;
  logic [KW-1:0] k;
  logic [N_INIMIGOS-1:0] anterior;
  logic [FATIA-1:0] mortas;
  logic [MW-1:0] mortes;
  logic b1, b2, ultima, aplica, zera;
  logic [SW-1:0] delta, soma, novo;
  always_comb begin
    mortas = anterior[k*FATIA +: FATIA] & ~inimigosvida[k*FATIA +: FATIA];
    mortes = '0;
    for (int i = 0; i < FATIA; i++) mortes = mortes + MW'(mortas[i]);
  end
  // Kills and the bonus share one adder; a single conditional subtract wraps since delta <= PLACAR_MAX+1.
  always_comb begin
    ultima = k == KW'(NF - 1);
    delta  = SW'(mortes) + ((b1 && !b2) ? SW'(PONTOS_BOLA) : SW'(0));
    soma   = SW'(placarAtual) + delta;
    novo   = soma > SW'(PLACAR_MAX) ? soma - SW'(PLACAR_MAX + 1) : soma;
    aplica = st == JOGANDO && !perdeuJogo && !reiniciarJogo;
    zera   = reiniciarJogo || st == OCIOSO;
  end
  always_comb begin
    st_n = reiniciarJogo                          ? OCIOSO  :
           (st == JOGANDO && perdeuJogo)          ? FIM     :
           (st == OCIOSO && iniciarJogo && pronto) ? JOGANDO : st;
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      st           <= OCIOSO;
      k            <= '0;
      anterior     <= '1;
      b1           <= 1'b0;
      b2           <= 1'b0;
      pronto       <= 1'b0;
      pontuou      <= 1'b0;
      placarAtual  <= '0;
      placarMaximo <= '0;
    end else begin
      st                          <= st_n;
      k                           <= ultima ? '0 : k + 1'b1;
      anterior[k*FATIA +: FATIA] <= inimigosvida[k*FATIA +: FATIA];
      b1                          <= bolaRebatida;
      b2                          <= b1;
      pontuou                     <= aplica && delta != '0;
      if (ultima) pronto <= 1'b1;
      if (aplica) begin
        placarAtual <= novo[9:0];
        if (novo[9:0] > placarMaximo) placarMaximo <= novo[9:0];
      end else if (zera) begin
        placarAtual <= '0;
      end
    end
  end
  assign estado = st;
endmodule
